// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Program loader that masters the PicoRV32 native memory port.
//               Collects a byte stream into little-endian 32-bit words and
//               writes NWORDS of them to consecutive addresses starting at
//               BASE_ADDR. The CPU is held in reset while a load runs. After
//               the last write is acknowledged, the memory port and the CPU
//               reset are released.
// Ports       :
//   clk             system clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_start         single-cycle load request (honoured in IDLE and DONE)
//   i_in_valid      byte stream valid
//   i_in_data       byte stream data
//   o_in_ready      byte accepted on this cycle's edge when i_in_valid is high
//   o_mem_valid     native-interface write request
//   o_mem_instr     always 0
//   i_mem_ready     responder acknowledge
//   o_mem_addr      write byte address
//   o_mem_wdata     write data
//   o_mem_wstrb     byte strobes
//   i_mem_rdata     unused (the loader only writes)
//   o_loader_active memory-port mux select, 1 = loader owns the BRAM port
//   o_cpu_reset_n   active-low CPU reset
//   o_done          load complete
//   o_word_cnt      words written and acknowledged in the current load
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int unsigned NWORDS    = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          i_reset_n,
  input  logic                          i_start,
  input  logic                          i_in_valid,
  input  logic [7:0]                    i_in_data,
  output logic                          o_in_ready,
  output logic                          o_mem_valid,
  output logic                          o_mem_instr,
  input  logic                          i_mem_ready,
  output logic [31:0]                   o_mem_addr,
  output logic [31:0]                   o_mem_wdata,
  output logic [3:0]                    o_mem_wstrb,
  input  logic [31:0]                   i_mem_rdata,
  output logic                          o_loader_active,
  output logic                          o_cpu_reset_n,
  output logic                          o_done,
  output logic [$clog2(NWORDS+1)-1:0]   o_word_cnt
);

  localparam int unsigned      CNT_W    = $clog2(NWORDS + 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_byte_idx;
  logic [CNT_W-1:0] r_word_idx;
  logic [CNT_W-1:0] r_word_cnt;
  // Bytes 0..2 of the word being assembled; byte 3 goes straight into the
  // write-data register on the edge that accepts it.
  logic [23:0]      r_asm;
  logic             r_in_ready;
  logic             r_mem_valid;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_wstrb;
  logic             r_loader_active;
  logic             r_cpu_reset_n;
  logic             r_done;

  logic [31:0]      w_word_addr;
  logic             w_unused;

  assign w_word_addr = BASE_ADDR + (32'(r_word_idx) << 2);
  // Read data has no meaning for a write-only initiator.
  assign w_unused    = ^i_mem_rdata;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state         <= S_IDLE;
      r_byte_idx      <= 2'd0;
      r_word_idx      <= '0;
      r_word_cnt      <= '0;
      r_asm           <= 24'd0;
      r_in_ready      <= 1'b0;
      r_mem_valid     <= 1'b0;
      r_mem_addr      <= 32'd0;
      r_mem_wdata     <= 32'd0;
      r_mem_wstrb     <= 4'd0;
      r_loader_active <= 1'b0;
      r_cpu_reset_n   <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      unique case (r_state)
        // A start from DONE is a reload: it re-asserts CPU reset and takes
        // the memory port back before the first new byte arrives.
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state         <= S_COLLECT;
            r_byte_idx      <= 2'd0;
            r_word_idx      <= '0;
            r_word_cnt      <= '0;
            r_in_ready      <= 1'b1;
            r_loader_active <= 1'b1;
            r_cpu_reset_n   <= 1'b0;
            r_done          <= 1'b0;
          end
        end

        S_COLLECT: begin
          if (i_in_valid && r_in_ready) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            unique case (r_byte_idx)
              2'd0: r_asm[7:0]   <= i_in_data;
              2'd1: r_asm[15:8]  <= i_in_data;
              2'd2: r_asm[23:16] <= i_in_data;
              default: begin
                r_state     <= S_WRITE;
                r_in_ready  <= 1'b0;
                r_mem_valid <= 1'b1;
                r_mem_addr  <= w_word_addr;
                r_mem_wdata <= {i_in_data, r_asm};
                r_mem_wstrb <= 4'hF;
              end
            endcase
          end
        end

        // Request fields stay untouched until the acknowledge; the address
        // and data simply keep their last values afterwards.
        S_WRITE: begin
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            r_mem_wstrb <= 4'd0;
            r_word_cnt  <= r_word_cnt + C_ONE;
            if (r_word_idx == C_LAST) begin
              r_state         <= S_DONE;
              r_loader_active <= 1'b0;
              r_cpu_reset_n   <= 1'b1;
              r_done          <= 1'b1;
            end else begin
              r_word_idx <= r_word_idx + C_ONE;
              r_state    <= S_COLLECT;
              r_in_ready <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready      = r_in_ready;
  assign o_mem_valid     = r_mem_valid;
  assign o_mem_instr     = 1'b0;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_mem_wstrb     = r_mem_wstrb;
  assign o_loader_active = r_loader_active;
  assign o_cpu_reset_n   = r_cpu_reset_n;
  assign o_done          = r_done;
  assign o_word_cnt      = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader (NWORDS=4, BASE_ADDR=0).
//               A reference model turns the byte stream into little-endian
//               words at BASE_ADDR+4*i; a per-cycle driver plays byte source
//               and memory responder and records every acknowledged write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  localparam int          NW = 4;
  localparam logic [31:0] BA = 32'h0000_0000;
  localparam int          CW = $clog2(NW + 1);

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_start;
  logic          i_in_valid;
  logic [7:0]    i_in_data;
  logic          o_in_ready;
  logic          o_mem_valid;
  logic          o_mem_instr;
  logic          i_mem_ready;
  logic [31:0]   o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [3:0]    o_mem_wstrb;
  logic [31:0]   i_mem_rdata;
  logic          o_loader_active;
  logic          o_cpu_reset_n;
  logic          o_done;
  logic [CW-1:0] o_word_cnt;

  prog_loader #(.NWORDS(NW), .BASE_ADDR(BA)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_start(i_start),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_mem_valid(o_mem_valid), .o_mem_instr(o_mem_instr), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_rdata(i_mem_rdata), .o_loader_active(o_loader_active),
    .o_cpu_reset_n(o_cpu_reset_n), .o_done(o_done), .o_word_cnt(o_word_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus and model
  logic [7:0]  byte_q[$];
  logic [7:0]  stim[$];
  logic [31:0] exp_words[$];
  int          lat_arr[$];
  int          def_lat;
  int          gap_pct;
  int          stop_word;
  bit          start_noise;

  // Observations from the driver
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [3:0]  obs_strb[$];
  int          obs_cnt[$];
  int          obs_vcyc[$];
  int          n_unstable, n_inready_viol, n_own_viol, n_timing_viol;
  int          last_ack_cyc, done_cyc, end_cnt;
  logic [4:0]  end_flags;
  bit          to;

  // Fresh load of nbytes random bytes; expected words come from the rule
  // "byte k of word i lands in bits 8k+7:8k".
  task automatic prep_load(input int nbytes);
    byte_q.delete(); stim.delete(); exp_words.delete(); lat_arr.delete();
    obs_addr.delete(); obs_data.delete(); obs_strb.delete(); obs_cnt.delete(); obs_vcyc.delete();
    n_unstable = 0; n_inready_viol = 0; n_own_viol = 0; n_timing_viol = 0;
    last_ack_cyc = -10; done_cyc = -1; end_cnt = -1; end_flags = 'x;
    def_lat = 1; gap_pct = 0; stop_word = -1; start_noise = 0;
    for (int i = 0; i < nbytes; i++) begin
      stim.push_back(8'($urandom));
      byte_q.push_back(stim[i]);
    end
    for (int w = 0; w < nbytes / 4; w++)
      exp_words.push_back({stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]});
  endtask

  task automatic do_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Cycle-by-cycle byte source and memory responder; records every write at
  // its acknowledge and counts protocol violations along the way.
  task automatic drive_load(input int max_cycles, output bit timed_out);
    int          vcyc;
    int          lat;
    bit          acked_prev;
    bit          last_prev;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    vcyc = 0; acked_prev = 0; last_prev = 0; timed_out = 1;
    a0 = '0; d0 = '0; s0 = '0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      i_mem_ready = 1'b0; i_in_valid = 1'b0; i_start = 1'b0;
      if (acked_prev && !last_prev && o_in_ready !== 1'b1) n_timing_viol++;
      if (acked_prev && o_mem_valid !== 1'b0) n_timing_viol++;
      acked_prev = 0;
      if (o_done === 1'b1) begin
        done_cyc  = cyc;
        end_flags = {o_done, o_cpu_reset_n, o_loader_active, o_mem_valid, o_in_ready};
        end_cnt   = int'(o_word_cnt);
        timed_out = 0;
        break;
      end
      if (stop_word >= 0 && o_mem_valid === 1'b1 && obs_addr.size() == stop_word) begin
        timed_out = 0;
        break;
      end
      if (o_cpu_reset_n !== 1'b0 || o_loader_active !== 1'b1) n_own_viol++;
      if (start_noise) i_start = ($urandom_range(0, 3) == 0);
      if (o_mem_valid === 1'b1) begin
        if (o_in_ready !== 1'b0) n_inready_viol++;
        if (vcyc == 0) begin
          a0 = o_mem_addr; d0 = o_mem_wdata; s0 = o_mem_wstrb;
        end else if (o_mem_addr !== a0 || o_mem_wdata !== d0 || o_mem_wstrb !== s0) begin
          n_unstable++;
        end
        vcyc++;
        // Junk on the byte port while the write waits must not be consumed.
        i_in_valid = 1'($urandom_range(0, 1));
        i_in_data  = 8'($urandom);
        lat = (obs_addr.size() < lat_arr.size()) ? lat_arr[obs_addr.size()] : def_lat;
        if (vcyc >= lat) begin
          i_mem_ready = 1'b1;
          obs_addr.push_back(a0); obs_data.push_back(d0); obs_strb.push_back(s0);
          obs_cnt.push_back(int'(o_word_cnt)); obs_vcyc.push_back(vcyc);
          vcyc = 0; acked_prev = 1; last_prev = (obs_addr.size() == NW); last_ack_cyc = cyc;
        end
      end else begin
        vcyc = 0;
        // Stray acknowledges with no request pending must be ignored.
        i_mem_ready = ($urandom_range(0, 3) == 0);
        if (o_in_ready === 1'b1) begin
          if (byte_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
            i_in_valid = 1'b1;
            i_in_data  = byte_q.pop_front();
          end
        end else begin
          i_in_valid = 1'($urandom_range(0, 1));
          i_in_data  = 8'($urandom);
        end
      end
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_start = 1'b1; i_in_valid = 1'b1; i_in_data = 8'hA5; i_mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_in_ready, o_mem_valid, o_loader_active, o_cpu_reset_n, o_done, o_mem_instr} !== 6'b0 ||
        o_mem_addr !== 32'd0 || o_mem_wdata !== 32'd0 || o_mem_wstrb !== 4'd0 || o_word_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b mv=%b act=%b crn=%b done=%b addr=%h wd=%h ws=%h cnt=%0d, required all 0",
               o_in_ready, o_mem_valid, o_loader_active, o_cpu_reset_n, o_done, o_mem_addr, o_mem_wdata, o_mem_wstrb, o_word_cnt);
    end
    i_start = 1'b0; i_mem_ready = 1'b0; i_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_in_ready, o_mem_valid, o_loader_active, o_cpu_reset_n, o_done} !== 5'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: rdy=%b mv=%b act=%b crn=%b done=%b, required all 0",
               o_in_ready, o_mem_valid, o_loader_active, o_cpu_reset_n, o_done);
    end
    i_in_valid = 1'b0;
  endtask

  task automatic test_basic_load();
    prep_load(0);
    byte_q = {8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'hF0, 8'h5F, 8'hFF};
    exp_words = {32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 32'hFF5F_F06F};
    do_start();
    n_cmp++;
    if ({o_in_ready, o_loader_active, o_cpu_reset_n, o_done} !== 4'b1100 || o_word_cnt !== '0) begin
      n_err++;
      $display("FAIL basic_start: rdy=%b act=%b crn=%b done=%b cnt=%0d, required 1 1 0 0 0",
               o_in_ready, o_loader_active, o_cpu_reset_n, o_done, o_word_cnt);
    end
    drive_load(1000, to);
    n_cmp++;
    if (to || obs_addr.size() != NW) begin
      n_err++; $display("FAIL basic_count: writes=%0d timeout=%0b, required %0d writes", obs_addr.size(), to, NW);
    end
    foreach (obs_addr[i]) begin
      n_cmp++;
      if (obs_addr[i] !== BA + 32'(4*i) || obs_data[i] !== exp_words[i] || obs_strb[i] !== 4'hF || obs_cnt[i] != i) begin
        n_err++;
        $display("FAIL basic_w%0d: addr=%h data=%h strb=%h cnt=%0d, required %h %h f %0d",
                 i, obs_addr[i], obs_data[i], obs_strb[i], obs_cnt[i], BA + 32'(4*i), exp_words[i], i);
      end
    end
    n_cmp++;
    if (end_flags !== 5'b11000 || end_cnt != NW || done_cyc != last_ack_cyc + 1 ||
        n_unstable + n_inready_viol + n_own_viol + n_timing_viol != 0) begin
      n_err++;
      $display("FAIL basic_done: flags=%b cnt=%0d done_lag=%0d viol=%0d/%0d/%0d/%0d, required 11000 %0d 1 0/0/0/0",
               end_flags, end_cnt, done_cyc - last_ack_cyc, n_unstable, n_inready_viol, n_own_viol, n_timing_viol, NW);
    end
  endtask

  task automatic test_backpressure();
    prep_load(4 * NW);
    lat_arr = {1, 5, 1, 1};
    do_start();
    drive_load(1000, to);
    n_cmp++;
    if (to || obs_addr.size() != NW || obs_vcyc[1] != 5 || obs_vcyc[2] != 1 ||
        n_unstable != 0 || n_inready_viol != 0 || n_timing_viol != 0) begin
      n_err++;
      $display("FAIL bp_hold: writes=%0d timeout=%0b w1_cycles=%0d unstable=%0d rdy_viol=%0d timing=%0d, required %0d 0 5 0 0 0",
               obs_addr.size(), to, (obs_vcyc.size() > 1) ? obs_vcyc[1] : -1, n_unstable, n_inready_viol, n_timing_viol, NW);
    end
    foreach (obs_addr[i]) begin
      n_cmp++;
      if (obs_addr[i] !== BA + 32'(4*i) || obs_data[i] !== exp_words[i] || obs_strb[i] !== 4'hF || obs_cnt[i] != i) begin
        n_err++;
        $display("FAIL bp_w%0d: addr=%h data=%h strb=%h cnt=%0d, required %h %h f %0d",
                 i, obs_addr[i], obs_data[i], obs_strb[i], obs_cnt[i], BA + 32'(4*i), exp_words[i], i);
      end
    end
  endtask

  task automatic test_stream_gaps();
    prep_load(4 * NW);
    gap_pct = 50;
    def_lat = 2;
    do_start();
    drive_load(2000, to);
    n_cmp++;
    if (to || obs_addr.size() != NW || end_flags !== 5'b11000 || end_cnt != NW) begin
      n_err++;
      $display("FAIL gaps_done: writes=%0d timeout=%0b flags=%b cnt=%0d, required %0d 0 11000 %0d",
               obs_addr.size(), to, end_flags, end_cnt, NW, NW);
    end
    foreach (obs_addr[i]) begin
      n_cmp++;
      if (obs_addr[i] !== BA + 32'(4*i) || obs_data[i] !== exp_words[i] || obs_strb[i] !== 4'hF) begin
        n_err++;
        $display("FAIL gaps_w%0d: addr=%h data=%h strb=%h, required %h %h f",
                 i, obs_addr[i], obs_data[i], obs_strb[i], BA + 32'(4*i), exp_words[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    prep_load(4 * NW);
    stop_word = 2;
    do_start();
    drive_load(1000, to);
    n_cmp++;
    if (to || o_mem_valid !== 1'b1 || obs_addr.size() != 2) begin
      n_err++;
      $display("FAIL midrst_reach: timeout=%0b mv=%b writes=%0d, required 0 1 2", to, o_mem_valid, obs_addr.size());
    end
    #2 i_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_mem_valid, o_in_ready, o_loader_active, o_cpu_reset_n, o_done} !== 5'b0 ||
        o_mem_wstrb !== 4'd0 || o_word_cnt !== '0) begin
      n_err++;
      $display("FAIL midrst_async: mv=%b rdy=%b act=%b crn=%b done=%b ws=%h cnt=%0d, required all 0",
               o_mem_valid, o_in_ready, o_loader_active, o_cpu_reset_n, o_done, o_mem_wstrb, o_word_cnt);
    end
    @(negedge clk);
    i_reset_n = 1'b1;
    prep_load(4 * NW);
    def_lat = 3;
    do_start();
    drive_load(1000, to);
    n_cmp++;
    if (to || obs_addr.size() != NW || end_flags !== 5'b11000 || end_cnt != NW) begin
      n_err++;
      $display("FAIL midrst_reload: writes=%0d timeout=%0b flags=%b cnt=%0d, required %0d 0 11000 %0d",
               obs_addr.size(), to, end_flags, end_cnt, NW, NW);
    end
    foreach (obs_addr[i]) begin
      n_cmp++;
      if (obs_addr[i] !== BA + 32'(4*i) || obs_data[i] !== exp_words[i] || obs_cnt[i] != i) begin
        n_err++;
        $display("FAIL midrst_w%0d: addr=%h data=%h cnt=%0d, required %h %h %0d",
                 i, obs_addr[i], obs_data[i], obs_cnt[i], BA + 32'(4*i), exp_words[i], i);
      end
    end
  endtask

  task automatic test_start_handling();
    prep_load(4 * NW);
    start_noise = 1;
    def_lat = 2;
    do_start();
    drive_load(1000, to);
    n_cmp++;
    if (to || obs_addr.size() != NW || end_flags !== 5'b11000 || end_cnt != NW || n_own_viol != 0) begin
      n_err++;
      $display("FAIL start_ignored: writes=%0d timeout=%0b flags=%b cnt=%0d own_viol=%0d, required %0d 0 11000 %0d 0",
               obs_addr.size(), to, end_flags, end_cnt, n_own_viol, NW, NW);
    end
    foreach (obs_addr[i]) begin
      n_cmp++;
      if (obs_addr[i] !== BA + 32'(4*i) || obs_data[i] !== exp_words[i] || obs_cnt[i] != i) begin
        n_err++;
        $display("FAIL start_noise_w%0d: addr=%h data=%h cnt=%0d, required %h %h %0d",
                 i, obs_addr[i], obs_data[i], obs_cnt[i], BA + 32'(4*i), exp_words[i], i);
      end
    end
    // Sit in DONE a few cycles, then reload.
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_done, o_cpu_reset_n, o_loader_active} !== 3'b110 || o_word_cnt !== CW'(NW)) begin
      n_err++;
      $display("FAIL done_hold: done=%b crn=%b act=%b cnt=%0d, required 1 1 0 %0d",
               o_done, o_cpu_reset_n, o_loader_active, o_word_cnt, NW);
    end
    prep_load(4 * NW);
    do_start();
    n_cmp++;
    if ({o_done, o_cpu_reset_n, o_loader_active, o_in_ready} !== 4'b0011 || o_word_cnt !== '0) begin
      n_err++;
      $display("FAIL reload_start: done=%b crn=%b act=%b rdy=%b cnt=%0d, required 0 0 1 1 0",
               o_done, o_cpu_reset_n, o_loader_active, o_in_ready, o_word_cnt);
    end
    drive_load(1000, to);
    n_cmp++;
    if (to || obs_addr.size() != NW || obs_addr[0] !== BA || end_flags !== 5'b11000) begin
      n_err++;
      $display("FAIL reload_done: writes=%0d timeout=%0b first_addr=%h flags=%b, required %0d 0 %h 11000",
               obs_addr.size(), to, (obs_addr.size() > 0) ? obs_addr[0] : 32'hx, end_flags, NW, BA);
    end
    foreach (obs_addr[i]) begin
      n_cmp++;
      if (obs_addr[i] !== BA + 32'(4*i) || obs_data[i] !== exp_words[i]) begin
        n_err++;
        $display("FAIL reload_w%0d: addr=%h data=%h, required %h %h",
                 i, obs_addr[i], obs_data[i], BA + 32'(4*i), exp_words[i]);
      end
    end
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 4; it++) begin
      prep_load(4 * NW);
      for (int w = 0; w < NW; w++) lat_arr.push_back($urandom_range(1, 4));
      gap_pct     = $urandom_range(0, 70);
      start_noise = 1'($urandom_range(0, 1));
      do_start();
      drive_load(2000, to);
      n_cmp++;
      if (to || obs_addr.size() != NW || end_flags !== 5'b11000 || end_cnt != NW || done_cyc != last_ack_cyc + 1 ||
          n_unstable + n_inready_viol + n_own_viol + n_timing_viol != 0) begin
        n_err++;
        $display("FAIL rand%0d_done: writes=%0d timeout=%0b flags=%b cnt=%0d viol=%0d/%0d/%0d/%0d, required %0d 0 11000 %0d 0/0/0/0",
                 it, obs_addr.size(), to, end_flags, end_cnt, n_unstable, n_inready_viol, n_own_viol, n_timing_viol, NW, NW);
      end
      foreach (obs_addr[i]) begin
        n_cmp++;
        if (obs_addr[i] !== BA + 32'(4*i) || obs_data[i] !== exp_words[i] || obs_strb[i] !== 4'hF || obs_cnt[i] != i) begin
          n_err++;
          $display("FAIL rand%0d_w%0d: addr=%h data=%h strb=%h cnt=%0d, required %h %h f %0d",
                   it, i, obs_addr[i], obs_data[i], obs_strb[i], obs_cnt[i], BA + 32'(4*i), exp_words[i], i);
        end
      end
    end
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_start     = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = 8'd0;
    i_mem_ready = 1'b0;
    i_mem_rdata = 32'hDEAD_BEEF;
    test_reset();
    test_basic_load();
    test_backpressure();
    test_stream_gaps();
    test_reset_mid_op();
    test_start_handling();
    test_random_loads();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
